// File: rtl/rect_line_sched.sv
// rect_line_sched: double-buffered rectangle descriptors, raster tracking and
// per-line active-rectangle mask scheduling during horizontal blanking.
module rect_line_sched #(
  parameter int RECT_N = 8,
  parameter int IMG_X  = 640,
  parameter int IMG_Y  = 480,
  parameter int P_W    = 11
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [RECT_N*32-1:0] item,
  input  logic                i_item_update,
  input  logic                i_post_camvs,
  input  logic                i_valid,
  output logic [RECT_N-1:0]   o_line_mask,
  output logic                o_mask_valid,
  output logic [P_W-1:0]      o_line_y,
  output logic                o_overrun
);
  localparam int K_W = RECT_N > 1 ? $clog2(RECT_N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, PUB} state_t;
  state_t state, state_n;
  logic [RECT_N*32-1:0] pend, act;
  logic                 vs_d;
  logic [P_W-1:0]       cnt_x, cnt_y, tgt_y;
  logic [K_W-1:0]       k;
  logic [RECT_N-1:0]    shadow;
  logic                 vs_rise, eol, last_line, start, k_last, hit, unused_act;
  logic [7:0]           y_min, y_max;
  assign vs_rise   = i_post_camvs & ~vs_d;
  assign eol       = i_post_camvs & i_valid & (cnt_x == P_W'(IMG_X - 1));
  assign last_line = cnt_y == P_W'(IMG_Y - 1);
  assign start     = (state == IDLE) & (vs_rise | (eol & ~last_line));
  assign k_last    = k == K_W'(RECT_N - 1);
  assign y_min     = act[32*k+16 +: 8];
  assign y_max     = act[32*k +: 8];
  // x fields travel with the descriptor but only the overlay datapath uses them
  assign unused_act = ^act;
  assign hit = (tgt_y >= P_W'({y_min, 2'b00})) & (tgt_y <= P_W'({y_max, 2'b11}));
  always_comb begin
    state_n = !i_post_camvs ? IDLE :
              start ? SCAN :
              (state == SCAN && k_last) ? PUB :
              state == PUB ? IDLE : state;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend         <= '0;
      act          <= '0;
      vs_d         <= 1'b0;
      cnt_x        <= '0;
      cnt_y        <= '0;
      tgt_y        <= '0;
      k            <= '0;
      shadow       <= '0;
      o_line_mask  <= '0;
      o_mask_valid <= 1'b0;
      o_line_y     <= '0;
      o_overrun    <= 1'b0;
    end else begin
      vs_d <= i_post_camvs;
      if (i_item_update) pend <= item;
      if (vs_rise) act <= i_item_update ? item : pend;
      if (!i_post_camvs) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end else if (i_valid) begin
        cnt_x <= eol ? '0 : cnt_x + 1'b1;
        if (eol) cnt_y <= last_line ? '0 : cnt_y + 1'b1;
      end
      if (start) begin
        tgt_y <= vs_rise ? '0 : cnt_y + 1'b1;
        k     <= '0;
      end else if (state == SCAN) begin
        shadow[k] <= hit;
        k         <= k + 1'b1;
      end
      o_mask_valid <= i_post_camvs & (state == PUB);
      // an aborted frame or the end of the last line leaves no rectangle armed
      if (!i_post_camvs || (eol && last_line)) o_line_mask <= '0;
      else if (state == PUB) begin
        o_line_mask <= shadow;
        o_line_y    <= tgt_y;
      end
      if (vs_rise) o_overrun <= 1'b0;
      else if (i_post_camvs && i_valid && state != IDLE) o_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rect_line_sched.sv
// tb_rect_line_sched: directed frames with a narrow raster, checked against a
// table of hand-computed per-line masks plus timing/abort/reset sequences.
module tb_rect_line_sched;
  localparam int N = 8;
  localparam int IX = 8;
  logic             sys_clk, sys_rst_n;
  logic [N*32-1:0]  item;
  logic             i_item_update, i_post_camvs, i_valid;
  logic [N-1:0]     o_line_mask;
  logic             o_mask_valid;
  logic [10:0]      o_line_y;
  logic             o_overrun;
  rect_line_sched #(.RECT_N(N), .IMG_X(IX), .IMG_Y(480), .P_W(11)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .item(item),
    .i_item_update(i_item_update), .i_post_camvs(i_post_camvs), .i_valid(i_valid),
    .o_line_mask(o_line_mask), .o_mask_valid(o_mask_valid), .o_line_y(o_line_y),
    .o_overrun(o_overrun)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  typedef struct {int f; int y; logic [7:0] m; int c;} vec_t;
  vec_t tbl [0:31];
  int nv = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cur_frame = 0;
  bit [7:0] got_mask [0:4][0:511];
  int       got_cnt  [0:4][0:511];
  always @(negedge sys_clk)
    if (o_mask_valid && o_line_y < 11'd512) begin
      got_mask[cur_frame][o_line_y] = o_line_mask;
      got_cnt[cur_frame][o_line_y]  = got_cnt[cur_frame][o_line_y] + 1;
    end
  task automatic add(input int f, input int y, input logic [7:0] m, input int c);
    tbl[nv] = '{f, y, m, c};
    nv++;
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  function automatic logic [31:0] d(input logic [7:0] ymin, input logic [7:0] ymax);
    return {8'd0, ymin, 8'd10, ymax};
  endfunction
  // vsync rise, optionally with a coincident update; returns edges until o_mask_valid
  task automatic vs_up(input bit upd, input logic [N*32-1:0] it, output int lat);
    i_post_camvs = 1'b1;
    i_item_update = upd;
    if (upd) item = it;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      tick;
      i_item_update = 1'b0;
      if (o_mask_valid && lat < 0) lat = n;
    end
  endtask
  // one line of pixels then blank idle cycles; lat counts edges from the last pixel
  task automatic do_line(input int blank, output int lat);
    for (int i = 0; i < IX; i++) begin
      i_valid = 1'b1;
      tick;
    end
    i_valid = 1'b0;
    lat = -1;
    for (int n = 2; n <= blank + 1; n++) begin
      tick;
      if (o_mask_valid && lat < 0) lat = n;
    end
  endtask
  task automatic run_lines(input int from, input int to, input int upd_y, input logic [N*32-1:0] it);
    int lat;
    for (int y = from; y <= to; y++) begin
      if (y == upd_y) begin
        item = it;
        i_item_update = 1'b1;
        tick;
        i_item_update = 1'b0;
      end
      do_line(12, lat);
    end
  endtask
  task automatic vs_down;
    i_post_camvs = 1'b0;
    tick;
    tick;
  endtask
  logic [N*32-1:0] set_a, set_b;
  int lat;
  initial begin
    for (int i = 0; i < N; i++) begin
      set_a[32*i +: 32] = d(8'd1, 8'd0);
      set_b[32*i +: 32] = d(8'd1, 8'd0);
    end
    set_a[31:0]    = d(8'd2, 8'd3);
    set_b[31:0]    = d(8'd25, 8'd25);
    set_b[191:160] = d(8'd25, 8'd25);
    set_b[95:64]   = d(8'd30, 8'd20);
    set_b[255:224] = d(8'd119, 8'd119);
    add(0, 0, 8'h00, 1); add(0, 7, 8'h00, 1); add(0, 8, 8'h01, 1); add(0, 12, 8'h01, 1);
    add(0, 15, 8'h01, 1); add(0, 16, 8'h00, 1); add(0, 100, 8'h00, 1); add(0, 476, 8'h00, 1);
    add(1, 0, 8'h00, 1); add(1, 8, 8'h00, 1); add(1, 99, 8'h00, 1); add(1, 100, 8'h21, 1);
    add(1, 103, 8'h21, 1); add(1, 104, 8'h00, 1); add(1, 476, 8'h80, 1); add(1, 479, 8'h80, 1);
    add(2, 1, 8'h00, 1);
    add(3, 0, 8'h00, 1); add(3, 8, 8'h01, 1); add(3, 9, 8'h01, 1); add(3, 10, 8'h00, 0);
    add(4, 6, 8'h00, 1); add(4, 8, 8'h01, 1);
    sys_rst_n = 1'b0;
    item = '0;
    i_item_update = 1'b0;
    i_post_camvs = 1'b0;
    i_valid = 1'b0;
    tick;
    tick;
    chk("rst_mask", o_line_mask, 0);
    chk("rst_valid", o_mask_valid, 0);
    chk("rst_line_y", o_line_y, 0);
    chk("rst_overrun", o_overrun, 0);
    sys_rst_n = 1'b1;
    tick;
    item = set_a;
    i_item_update = 1'b1;
    tick;
    i_item_update = 1'b0;
    tick;
    cur_frame = 0;
    vs_up(1'b0, '0, lat);
    chk("vs_latency", lat, N + 2);
    run_lines(0, 6, -1, '0);
    do_line(12, lat);
    chk("eol_latency", lat, N + 2);
    run_lines(8, 478, 50, set_b);
    do_line(12, lat);
    vs_down;
    cur_frame = 1;
    vs_up(1'b0, '0, lat);
    run_lines(0, 98, -1, '0);
    chk("overrun_before", o_overrun, 0);
    do_line(4, lat);
    do_line(12, lat);
    chk("overrun_set", o_overrun, 1);
    run_lines(101, 478, -1, '0);
    do_line(0, lat);
    chk("eof_mask_clear", o_line_mask, 0);
    chk("eof_no_pulse", o_mask_valid, 0);
    for (int i = 0; i < 12; i++) tick;
    cur_frame = 2;
    do_line(12, lat);
    chk("wrap_latency", lat, N + 2);
    chk("wrap_line_y", o_line_y, 1);
    vs_down;
    cur_frame = 3;
    vs_up(1'b1, set_a, lat);
    chk("overrun_clear", o_overrun, 0);
    run_lines(0, 8, -1, '0);
    do_line(0, lat);
    tick;
    tick;
    chk("abort_pre_mask", o_line_mask, 8'h01);
    i_post_camvs = 1'b0;
    tick;
    chk("abort_mask", o_line_mask, 0);
    chk("abort_valid", o_mask_valid, 0);
    for (int i = 0; i < 12; i++) tick;
    chk("abort_mask_hold", o_line_mask, 0);
    cur_frame = 4;
    vs_up(1'b0, '0, lat);
    run_lines(0, 4, -1, '0);
    do_line(4, lat);
    run_lines(6, 7, -1, '0);
    do_line(0, lat);
    tick;
    tick;
    chk("pre_rst_overrun", o_overrun, 1);
    chk("pre_rst_line_y", o_line_y, 8);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_mask", o_line_mask, 0);
    chk("async_rst_line_y", o_line_y, 0);
    chk("async_rst_overrun", o_overrun, 0);
    chk("async_rst_valid", o_mask_valid, 0);
    i_post_camvs = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    tick;
    for (int i = 0; i < nv; i++) begin
      chk($sformatf("f%0d_y%0d_pulses", tbl[i].f, tbl[i].y), got_cnt[tbl[i].f][tbl[i].y], tbl[i].c);
      if (tbl[i].c > 0)
        chk($sformatf("f%0d_y%0d_mask", tbl[i].f, tbl[i].y), {24'd0, got_mask[tbl[i].f][tbl[i].y]}, {24'd0, tbl[i].m});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
